// File: rtl/tilegame_pkg.sv
// Shared definitions for the tile game keyboard path.
//   - PS/2 set-2 scancode constants (prefixes and the game keys)
//   - parser state encoding, also driven out on state_dbg
//   - key index constants for the held bitmap {select,right,left,down,up}
//   - keyMask(): maps a scancode to a one-hot key mask
package tilegame_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    // The receiver reports framing/parity problems as all-zeros or all-ones.
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    localparam int NUM_KEYS = 5;
    localparam int K_UP     = 0;
    localparam int K_DOWN   = 1;
    localparam int K_LEFT   = 2;
    localparam int K_RIGHT  = 3;
    localparam int K_SEL    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parserState_e;

    // Arrows are recognised with or without the E0 prefix (some keyboards
    // send the keypad code); space is only valid as a plain code.
    function automatic logic [NUM_KEYS-1:0] keyMask(input logic [7:0] code,
                                                     input logic       ext);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        case (code)
            SC_UP:    mask[K_UP]    = 1'b1;
            SC_DOWN:  mask[K_DOWN]  = 1'b1;
            SC_LEFT:  mask[K_LEFT]  = 1'b1;
            SC_RIGHT: mask[K_RIGHT] = 1'b1;
            SC_SPACE: mask[K_SEL]   = ~ext;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher.
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   trig     : one-cycle request; (re)loads the counter with STRETCH
//   pulse    : high while the counter is nonzero, i.e. STRETCH cycles
//              starting the cycle after trig
module pulse_stretch #(
    parameter int STRETCH = 4
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic trig,
    output logic pulse
);

    localparam int            CW   = $clog2(STRETCH + 1);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder for the game keys.
//   CLOCK_50   : 50 MHz system clock
//   resetn     : asynchronous active-low reset
//   rx_data    : scancode byte from the PS/2 receiver
//   rx_valid   : byte strobe from the receiver
//   key_up/down/left/right/select : press pulses, STRETCH cycles wide,
//                one per make of a key that was not already held
//   held       : level bitmap {select,right,left,down,up} of held keys
//   state_dbg  : parser state (IDLE/EXT/BRK/EXT_BRK) for the HEX display
//
// Handshake: rx_valid is a one-cycle strobe with no ready/back-pressure;
// every cycle with rx_valid=1 delivers exactly one byte and is consumed in
// that cycle, so back-to-back strobes are back-to-back bytes.
module ps2_key_decoder
    import tilegame_pkg::*;
#(
    parameter int STRETCH = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_select,
    output logic [4:0] held,
    output logic [1:0] state_dbg
);

    localparam int            TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    parserState_e        state, nextState;
    logic [TW-1:0]       toCnt, toCntNext;
    logic [NUM_KEYS-1:0] heldReg, heldNext;
    logic [NUM_KEYS-1:0] trig;
    logic [NUM_KEYS-1:0] makeMask, breakMask;
    logic                isExt, isBrk, isErr;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            heldReg <= '0;
            toCnt   <= '0;
        end else begin
            state   <= nextState;
            heldReg <= heldNext;
            toCnt   <= toCntNext;
        end
    end

    always_comb begin
        nextState = state;
        heldNext  = heldReg;
        trig      = '0;
        isExt     = (rx_data == SC_EXT);
        isBrk     = (rx_data == SC_BRK);
        isErr     = (rx_data == SC_ERR_LO) || (rx_data == SC_ERR_HI);
        // Only one of make/break applies per byte; the state picks which
        // and whether the E0 prefix was seen.
        makeMask  = keyMask(rx_data, state == EXT);
        breakMask = keyMask(rx_data, state == EXT_BRK);

        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (isExt) begin
                        nextState = EXT;
                    end else if (isBrk) begin
                        nextState = BRK;
                    end else if (isErr) begin
                        heldNext = '0;
                    end else begin
                        // A make of an already-held key is typematic repeat.
                        trig     = makeMask & ~heldReg;
                        heldNext = heldReg | makeMask;
                    end
                end
                EXT: begin
                    if (isBrk) begin
                        nextState = EXT_BRK;
                    end else if (isExt) begin
                        nextState = EXT;
                    end else if (isErr) begin
                        heldNext  = '0;
                        nextState = IDLE;
                    end else begin
                        trig      = makeMask & ~heldReg;
                        heldNext  = heldReg | makeMask;
                        nextState = IDLE;
                    end
                end
                BRK: begin
                    if (isExt) begin
                        nextState = EXT_BRK;
                    end else if (isBrk) begin
                        nextState = BRK;
                    end else begin
                        heldNext  = heldReg & ~breakMask;
                        nextState = IDLE;
                    end
                end
                default: begin
                    if (isExt || isBrk) begin
                        nextState = EXT_BRK;
                    end else begin
                        heldNext  = heldReg & ~breakMask;
                        nextState = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE && toCnt == TO_LAST) begin
            // A prefix with no follow-up byte is dropped so a lost byte
            // cannot turn the next make into a break.
            nextState = IDLE;
        end
    end

    always_comb begin
        toCntNext = '0;
        if (!rx_valid && state != IDLE && toCnt != TO_LAST) begin
            toCntNext = toCnt + TO_ONE;
        end
    end

    pulse_stretch #(.STRETCH(STRETCH)) uStretchUp (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .trig(trig[K_UP]),    .pulse(key_up)
    );
    pulse_stretch #(.STRETCH(STRETCH)) uStretchDown (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .trig(trig[K_DOWN]),  .pulse(key_down)
    );
    pulse_stretch #(.STRETCH(STRETCH)) uStretchLeft (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .trig(trig[K_LEFT]),  .pulse(key_left)
    );
    pulse_stretch #(.STRETCH(STRETCH)) uStretchRight (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .trig(trig[K_RIGHT]), .pulse(key_right)
    );
    pulse_stretch #(.STRETCH(STRETCH)) uStretchSel (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .trig(trig[K_SEL]),   .pulse(key_select)
    );

    assign held      = heldReg;
    assign state_dbg = state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scancode sequences with expected key
// pulses queued as they are sent and checked by an independent monitor.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int STRETCH = 4;
    localparam int TIMEOUT = 40;

    // ---------------- clock / reset ----------------
    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       key_up, key_down, key_left, key_right, key_select;
    logic [4:0] held;
    logic [1:0] state_dbg;
    logic [4:0] keys;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_decoder #(.STRETCH(STRETCH), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_select(key_select),
        .held      (held),
        .state_dbg (state_dbg)
    );

    assign keys = {key_select, key_right, key_left, key_down, key_up};

    // ---------------- scoreboard state ----------------
    logic [4:0] expQ[$];
    int         nChecks = 0;
    int         nPass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change #1 after the rising edge; consecutive calls give
    // back-to-back strobes.
    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    // Every rising key edge pops one expected rise vector; every falling
    // edge checks the pulse was exactly STRETCH cycles wide.
    logic [4:0] prevKeys = '0;
    logic [4:0] riseVec;
    int         width[5] = '{0, 0, 0, 0, 0};

    always @(negedge CLOCK_50) begin
        if (!resetn) begin
            prevKeys = '0;
            for (int k = 0; k < 5; k++) width[k] = 0;
        end else begin
            riseVec = keys & ~prevKeys;
            for (int k = 0; k < 5; k++) begin
                if (keys[k]) begin
                    width[k]++;
                end else if (prevKeys[k]) begin
                    check($sformatf("pulse_width_k%0d", k), 8'(width[k]), 8'(STRETCH));
                    width[k] = 0;
                end
            end
            if (riseVec != '0) begin
                if (expQ.size() == 0) check("unexpected_pulse", {3'b0, riseVec}, 8'h00);
                else check("pulse_keys", {3'b0, riseVec}, {3'b0, expQ.pop_front()});
            end
            prevKeys = keys;
        end
    end

    // ---------------- stimulus ----------------
    int overlap;

    initial begin
        resetn = 1'b0;
        idle(2);
        check("reset_held", {3'b0, held}, 8'h00);
        check("reset_state", {6'b0, state_dbg}, 8'h00);
        check("reset_keys", {3'b0, keys}, 8'h00);
        resetn = 1'b1;
        idle(2);

        // plain make / break of up
        expQ.push_back(5'b00001);
        sendByte(8'h75);
        check("mb_held_make", {3'b0, held}, 8'h01);
        idle(2);
        sendByte(8'hF0);
        check("mb_state_brk", {6'b0, state_dbg}, 8'h02);
        sendByte(8'h75);
        check("mb_held_break", {3'b0, held}, 8'h00);
        check("mb_state_idle", {6'b0, state_dbg}, 8'h00);
        idle(8);

        // extended left with typematic repeats
        expQ.push_back(5'b00100);
        sendByte(8'hE0);
        check("ext_state", {6'b0, state_dbg}, 8'h01);
        sendByte(8'h6B);
        check("ext_held_make", {3'b0, held}, 8'h04);
        repeat (2) begin
            sendByte(8'hE0);
            sendByte(8'h6B);
        end
        check("ext_held_repeat", {3'b0, held}, 8'h04);
        sendByte(8'hE0);
        sendByte(8'hF0);
        check("ext_state_extbrk", {6'b0, state_dbg}, 8'h03);
        check("ext_held_before_rel", {3'b0, held}, 8'h04);
        sendByte(8'h6B);
        check("ext_held_release", {3'b0, held}, 8'h00);
        idle(8);

        // space with E0 prefix is unmapped
        sendByte(8'hE0);
        sendByte(8'h29);
        check("e0_space_held", {3'b0, held}, 8'h00);
        check("e0_space_state", {6'b0, state_dbg}, 8'h00);
        idle(6);

        // select then right on back-to-back strobes
        expQ.push_back(5'b10000);
        expQ.push_back(5'b01000);
        sendByte(8'h29);
        sendByte(8'h74);
        check("simul_held", {3'b0, held}, 8'h18);
        overlap = 0;
        for (int i = 0; i < 8; i++) begin
            if (key_select && key_right) overlap++;
            idle(1);
        end
        check("simul_overlap", 8'(overlap), 8'd3);
        sendByte(8'hF0);
        sendByte(8'h29);
        sendByte(8'hF0);
        sendByte(8'h74);
        check("simul_held_released", {3'b0, held}, 8'h00);
        idle(4);

        // dangling E0 times out; the next 75 is a plain make
        sendByte(8'hE0);
        idle(TIMEOUT - 1);
        check("to_state_before", {6'b0, state_dbg}, 8'h01);
        idle(2);
        check("to_state_after", {6'b0, state_dbg}, 8'h00);
        expQ.push_back(5'b00001);
        sendByte(8'h75);
        check("to_held_make", {3'b0, held}, 8'h01);
        check("to_state_make", {6'b0, state_dbg}, 8'h00);
        idle(6);
        sendByte(8'hF0);
        sendByte(8'h75);
        check("to_held_release", {3'b0, held}, 8'h00);
        idle(2);

        // receiver error byte clears held
        expQ.push_back(5'b00001);
        sendByte(8'h75);
        expQ.push_back(5'b00010);
        sendByte(8'h72);
        check("err_held_before", {3'b0, held}, 8'h03);
        idle(6);
        sendByte(8'hFF);
        check("err_held_cleared", {3'b0, held}, 8'h00);
        check("err_state", {6'b0, state_dbg}, 8'h00);
        idle(6);
        expQ.push_back(5'b00010);
        sendByte(8'h72);
        check("err_held_after", {3'b0, held}, 8'h02);
        idle(6);
        sendByte(8'hF0);
        sendByte(8'h72);
        check("err_held_release", {3'b0, held}, 8'h00);
        idle(2);

        // reset during the second cycle of a pulse
        expQ.push_back(5'b00001);
        sendByte(8'h75);
        idle(1);
        resetn = 1'b0;
        #1;
        check("rst_mid_keys", {3'b0, keys}, 8'h00);
        check("rst_mid_held", {3'b0, held}, 8'h00);
        check("rst_mid_state", {6'b0, state_dbg}, 8'h00);
        idle(1);
        resetn = 1'b1;
        idle(6);

        check("queue_drained", 8'(expQ.size()), 8'h00);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between PS2_Controller (received_data / received_data_en) and the game FSMs.
- Parses raw PS/2 set-2 scancode bytes, including the E0 extended prefix and the F0 break prefix.
- Tracks which game keys are held and suppresses typematic auto-repeat.
- Emits a stretched press pulse per key, long enough for the pixel-clock double-flop synchronizers to capture. It replaces the inline scancode logic in the top level.

Parameters:
STRETCH, 4, press-pulse width in clock cycles (must be >= 2 for capture by the 25 MHz synchronizer)
TIMEOUT, 50000, idle cycles after which a dangling E0/F0 prefix is discarded (1 ms at 50 MHz)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
resetn  input  1  asynchronous active-low reset
rx_data  input  8  scancode byte from the PS/2 receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
key_up  output  1  up-arrow press pulse, STRETCH cycles wide
key_down  output  1  down-arrow press pulse
key_left  output  1  left-arrow press pulse
key_right  output  1  right-arrow press pulse
key_select  output  1  space-bar press pulse
held  output  5  held bitmap {select,right,left,down,up}, level
state_dbg  output  2  current parser state, for HEX debug

Behaviour:
- Key map:
  - 0x75 = up, 0x72 = down, 0x6B = left, 0x74 = right. Arrow codes are accepted with or without the E0 prefix.
  - 0x29 = select. Select is accepted only without E0.
  - All other codes are unmapped and ignored. They still return the FSM to IDLE.
- Reset (async, resetn=0): state IDLE, held=0, all stretch counters 0, all key_* outputs 0, timeout counter 0.
- FSM states:
  - IDLE=0: E0 -> EXT; F0 -> BRK; 0x00 or 0xFF (receiver error) -> clear held, stay IDLE; other bytes -> make(code, ext=0), stay IDLE.
  - EXT=1: F0 -> EXT_BRK; E0 -> stay EXT; 0x00/0xFF -> clear held, IDLE; other bytes -> make(code, ext=1), IDLE.
  - BRK=2: E0 -> EXT_BRK; F0 -> stay BRK; other bytes -> release(code, ext=0), IDLE.
  - EXT_BRK=3: F0/E0 -> stay; other bytes -> release(code, ext=1), IDLE.
- State transitions occur only on cycles with rx_valid=1, apart from the timeout.
- make(code):
  - If the code maps to key k and held[k]=0: set held[k], load stretch counter k with STRETCH.
  - If held[k]=1: no pulse. This is typematic repeat.
- release(code): if the code maps to key k, clear held[k]. A release of a key that is not held is a no-op.
- Timeout:
  - The counter resets to 0 on every rx_valid, and counts only while state != IDLE.
  - When it reaches TIMEOUT-1, force IDLE. held is unchanged.
- Stretch:
  - key_x = (cnt_x != 0). cnt_x decrements each cycle while nonzero.
  - A reload during an active pulse restarts it at STRETCH. This can only happen after a release/press pair.
- Latency: rx_valid at edge n -> key_x high from edge n+1 for exactly STRETCH cycles. held updates at edge n+1.
- Simultaneous keys: each key has an independent counter. Up to 5 key_x may be high together.
- rx_valid held high for consecutive cycles: each cycle is a separate byte. No back-pressure exists.
- Counter widths: stretch counter = clog2(STRETCH+1); timeout counter = clog2(TIMEOUT).

Decomposition:
- Package tilegame_pkg:
  - Scancode constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_SPACE.
  - Parser state encodings.
  - Key index constants K_UP=0 .. K_SEL=4.
- Sub-module pulse_stretch (parameter STRETCH; ports CLOCK_50, resetn, trig, pulse), instantiated 5 times.

Test Plan:
- Reset mid-pulse: send 75, assert resetn=0 for 1 cycle at cycle 2 of the pulse -> key_up drops immediately, held=0, state_dbg=0.
- Plain make/break: bytes 75, F0 75 -> key_up high for exactly 4 cycles starting 1 cycle after the first strobe; held[0]=1 then 0; no second pulse.
- Extended arrow with typematic: E0 6B, E0 6B, E0 6B, then E0 F0 6B -> one key_left pulse only; held[2] is 1 until the final byte, then 0.
- Simultaneous keys: 29 then 74 on back-to-back cycles -> key_select and key_right overlap for 3 cycles; held=5'b11000.
- Timeout: send E0, wait TIMEOUT cycles, send 75 -> state returns to IDLE at TIMEOUT-1; 75 is treated as a non-extended make and key_up pulses.
- Error byte: held=5'b00011, then byte FF -> held=0, no pulse; a subsequent 72 produces a key_down pulse.
